// File: rtl/skid_fifo_pipe_if.sv
// Handshake bundle for skid_fifo_pipe: upstream valid/ready/data, downstream
// valid/ready/data, flush control and occupancy status.
interface skid_fifo_pipe_if #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH + 2);

    logic             valid_i;
    logic             ready_i;
    logic [WIDTH-1:0] data_i;
    logic             valid_o;
    logic             ready_o;
    logic [WIDTH-1:0] data_o;
    logic             flush_i;
    logic [CW-1:0]    count_o;
    logic             afull_o;

    // Side that drives the pipe: produces upstream beats, consumes downstream ones.
    modport master (
        output valid_i, data_i, ready_o, flush_i,
        input  ready_i, valid_o, data_o, count_o, afull_o
    );

    // The pipe stage itself.
    modport slave (
        input  valid_i, data_i, ready_o, flush_i,
        output ready_i, valid_o, data_o, count_o, afull_o
    );
endinterface

// File: rtl/skid_fifo_pipe.sv
// Registered-ready pipe stage: one output register backed by a DEPTH-entry
// circular FIFO, with synchronous flush, occupancy count and almost-full flag.
module skid_fifo_pipe #(
    parameter int WIDTH    = 1,
    parameter int DEPTH    = 2,
    parameter int AFULL_TH = DEPTH
) (
    input  logic              clk,
    input  logic              rstN,
    skid_fifo_pipe_if.slave   bus
);
    localparam int CW = $clog2(DEPTH + 2);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);

    if (DEPTH < 1 || AFULL_TH < 1 || AFULL_TH > DEPTH + 1) begin : g_bad_params
        $error("skid_fifo_pipe: illegal DEPTH/AFULL_TH combination");
    end

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [CW-1:0]    bcnt_q;
    logic             ready_q;
    logic [CW-1:0]    count_q;
    logic             afull_q;

    logic             push;
    logic             refill;
    logic             drain;
    logic             load_in;
    logic             wr;
    logic             valid_n;
    logic [CW-1:0]    bcnt_n;
    logic [CW-1:0]    count_n;
    logic [PW-1:0]    head_n;
    logic [PW-1:0]    tail_n;

    // Output register takes the backup head first so ordering stays FIFO;
    // only an empty backup lets the incoming beat bypass straight to data_o.
    always_comb begin
        push    = bus.valid_i && ready_q;
        refill  = !valid_q || bus.ready_o;
        drain   = refill && (bcnt_q != '0);
        load_in = refill && !drain && push;
        wr      = push && !load_in;
        valid_n = refill ? (drain || push) : valid_q;
        bcnt_n  = bcnt_q + CW'(wr) - CW'(drain);
        count_n = CW'(valid_n) + bcnt_n;
        head_n  = head_q;
        tail_n  = tail_q;
        if (drain) begin
            head_n = (head_q == PTR_LAST) ? '0 : head_q + PW'(1);
        end
        if (wr) begin
            tail_n = (tail_q == PTR_LAST) ? '0 : tail_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            bcnt_q  <= '0;
            ready_q <= 1'b0;
            count_q <= '0;
            afull_q <= 1'b0;
        end else if (bus.flush_i) begin
            valid_q <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            bcnt_q  <= '0;
            ready_q <= 1'b1;
            count_q <= '0;
            afull_q <= 1'b0;
        end else begin
            valid_q <= valid_n;
            if (drain) begin
                data_q <= mem[head_q];
            end else if (load_in) begin
                data_q <= bus.data_i;
            end
            head_q  <= head_n;
            tail_q  <= tail_n;
            bcnt_q  <= bcnt_n;
            // Space for one more beat under the worst case of no pop next cycle.
            ready_q <= (bcnt_n < DEPTH_C);
            count_q <= count_n;
            afull_q <= (count_n >= AFULL_C);
        end
    end

    // Backup storage carries no reset; contents are meaningful only below bcnt.
    always_ff @(posedge clk) begin
        if (wr && !bus.flush_i) begin
            mem[tail_q] <= bus.data_i;
        end
    end

    assign bus.ready_i = ready_q;
    assign bus.valid_o = valid_q;
    assign bus.data_o  = data_q;
    assign bus.count_o = count_q;
    assign bus.afull_o = afull_q;
endmodule

// File: tb/tb_skid_fifo_pipe.sv
// Self-checking bench for skid_fifo_pipe: three configurations compared each
// cycle against a queue-based occupancy model.
module tb_skid_fifo_pipe;
    logic clk = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    skid_fifo_pipe_if #(.WIDTH(8),  .DEPTH(4)) if4 ();
    skid_fifo_pipe_if #(.WIDTH(16), .DEPTH(3)) if3 ();
    skid_fifo_pipe_if #(.WIDTH(8),  .DEPTH(1)) if1 ();

    skid_fifo_pipe #(.WIDTH(8),  .DEPTH(4), .AFULL_TH(4)) u4 (.clk(clk), .rstN(rstN), .bus(if4));
    skid_fifo_pipe #(.WIDTH(16), .DEPTH(3), .AFULL_TH(3)) u3 (.clk(clk), .rstN(rstN), .bus(if3));
    skid_fifo_pipe #(.WIDTH(8),  .DEPTH(1), .AFULL_TH(2)) u1 (.clk(clk), .rstN(rstN), .bus(if1));

    int checks = 0;
    int errors = 0;

    // Model: every held beat in arrival order; mq[0] is what data_o must show.
    int mq[$];
    bit m_ready;
    int m_depth;
    int m_th;

    logic        s_vo, s_ri, s_af;
    logic [31:0] s_d;
    logic [31:0] s_cnt;

    task automatic drive(input int which, input bit vi, input int di, input bit ro, input bit fl);
        case (which)
            4: begin if4.valid_i = vi; if4.data_i = 8'(di);  if4.ready_o = ro; if4.flush_i = fl; end
            3: begin if3.valid_i = vi; if3.data_i = 16'(di); if3.ready_o = ro; if3.flush_i = fl; end
            default: begin if1.valid_i = vi; if1.data_i = 8'(di); if1.ready_o = ro; if1.flush_i = fl; end
        endcase
    endtask

    task automatic sample(input int which);
        case (which)
            4: begin s_vo = if4.valid_o; s_d = 32'(if4.data_o); s_ri = if4.ready_i; s_cnt = 32'(if4.count_o); s_af = if4.afull_o; end
            3: begin s_vo = if3.valid_o; s_d = 32'(if3.data_o); s_ri = if3.ready_i; s_cnt = 32'(if3.count_o); s_af = if3.afull_o; end
            default: begin s_vo = if1.valid_o; s_d = 32'(if1.data_o); s_ri = if1.ready_i; s_cnt = 32'(if1.count_o); s_af = if1.afull_o; end
        endcase
    endtask

    task automatic apply_reset(input int depth, input int th);
        drive(4, 0, 0, 0, 0);
        drive(3, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        mq.delete();
        m_ready = 1'b0;
        m_depth = depth;
        m_th = th;
    endtask

    // Drives one cycle of stimulus, advances the model across the edge,
    // and returns at the following falling edge.
    task automatic tick(input int which, input bit vi, input int di, input bit ro, input bit fl,
                        output bit pushed);
        bit pop;
        drive(which, vi, di, ro, fl);
        pushed = vi && m_ready;
        pop = (mq.size() > 0) && ro;
        if (fl) begin
            mq.delete();
            m_ready = 1'b1;
        end else begin
            if (pop) void'(mq.pop_front());
            if (pushed) mq.push_back(di);
            m_ready = (mq.size() <= m_depth);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        bit p;
        drive(4, 1, 'h33, 0, 0);
        rstN = 1'b0;
        repeat (3) @(negedge clk);
        sample(4);
        checks++;
        if (s_ri !== 1'b0 || s_vo !== 1'b0 || s_cnt !== 0 || s_af !== 1'b0 || s_d !== 0) begin
            errors++;
            $display("FAIL reset_hold: ready=%b valid=%b count=%0d afull=%b data=%0h, want 0 0 0 0 0",
                     s_ri, s_vo, s_cnt, s_af, s_d);
        end
        rstN = 1'b1;
        mq.delete(); m_ready = 1'b0; m_depth = 4; m_th = 4;
        for (int k = 0; k < 4; k++) begin
            tick(4, 1, 'h5A + k, 0, 0, p);
            sample(4);
            checks++;
            if (s_vo !== (mq.size() > 0) || s_ri !== m_ready || s_cnt !== mq.size()) begin
                errors++;
                $display("FAIL reset_release cyc%0d: valid=%b ready=%b count=%0d, want %b %b %0d",
                         k, s_vo, s_ri, s_cnt, mq.size() > 0, m_ready, mq.size());
            end
            if (mq.size() > 0) begin
                checks++;
                if (s_d !== mq[0]) begin
                    errors++;
                    $display("FAIL reset_first_beat cyc%0d: data=%0h want %0h", k, s_d, mq[0]);
                end
            end
        end
        // Asynchronous reset while holding data must clear valid without an edge.
        #2 rstN = 1'b0;
        #1 sample(4);
        checks++;
        if (s_vo !== 1'b0 || s_cnt !== 0 || s_ri !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: valid=%b count=%0d ready=%b, want 0 0 0", s_vo, s_cnt, s_ri);
        end
    endtask

    task automatic test_streaming();
        bit p;
        int nxt = 0;
        apply_reset(4, 4);
        tick(4, 0, 0, 1, 0, p);
        for (int i = 0; i < 104; i++) begin
            tick(4, i < 100, i, 1, 0, p);
            sample(4);
            checks++;
            if (s_ri !== 1'b1 || s_vo !== (mq.size() > 0) || s_cnt !== mq.size()) begin
                errors++;
                $display("FAIL stream cyc%0d: ready=%b valid=%b count=%0d, want 1 %b %0d",
                         i, s_ri, s_vo, s_cnt, mq.size() > 0, mq.size());
            end
            if (s_vo === 1'b1) begin
                checks++;
                if (s_d !== nxt) begin
                    errors++;
                    $display("FAIL stream_order cyc%0d: data=%0d want %0d", i, s_d, nxt);
                end
                nxt++;
            end
        end
        checks++;
        if (nxt != 100) begin
            errors++;
            $display("FAIL stream_total: delivered %0d want 100", nxt);
        end
    endtask

    task automatic test_backpressure();
        bit p;
        int v = 0;
        apply_reset(4, 4);
        tick(4, 0, 0, 0, 0, p);
        for (int i = 0; i < 8; i++) begin
            tick(4, 1, v, 0, 0, p);
            if (p) v++;
            sample(4);
            if (v == 4) begin
                checks++;
                if (s_af !== 1'b1 || s_cnt !== 4 || s_ri !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_afull: afull=%b count=%0d ready=%b, want 1 4 1", s_af, s_cnt, s_ri);
                end
            end
        end
        checks++;
        if (v != 5 || s_cnt !== 5 || s_ri !== 1'b0 || s_af !== 1'b1 || s_d !== 0) begin
            errors++;
            $display("FAIL bp_full: accepted=%0d count=%0d ready=%b afull=%b data=%0d, want 5 5 0 1 0",
                     v, s_cnt, s_ri, s_af, s_d);
        end
        for (int i = 0; i < 20; i++) begin
            tick(4, i < 12, v, 1, 0, p);
            if (p) v++;
            sample(4);
            checks++;
            if (s_vo !== (mq.size() > 0) || s_ri !== m_ready || s_cnt !== mq.size()
                || s_af !== (mq.size() >= m_th)) begin
                errors++;
                $display("FAIL bp_drain cyc%0d: valid=%b ready=%b count=%0d afull=%b, want %b %b %0d %b",
                         i, s_vo, s_ri, s_cnt, s_af, mq.size() > 0, m_ready, mq.size(), mq.size() >= m_th);
            end
            if (mq.size() > 0) begin
                checks++;
                if (s_d !== mq[0]) begin
                    errors++;
                    $display("FAIL bp_data cyc%0d: data=%0d want %0d", i, s_d, mq[0]);
                end
            end
        end
    endtask

    task automatic test_flush();
        bit p;
        apply_reset(4, 4);
        tick(4, 0, 0, 0, 0, p);
        for (int i = 0; i < 6; i++) tick(4, 1, i + 1, 0, 0, p);
        tick(4, 1, 'hAA, 0, 1, p);
        sample(4);
        checks++;
        if (s_vo !== 1'b0 || s_cnt !== 0 || s_ri !== 1'b1 || s_af !== 1'b0) begin
            errors++;
            $display("FAIL flush_full: valid=%b count=%0d ready=%b afull=%b, want 0 0 1 0",
                     s_vo, s_cnt, s_ri, s_af);
        end
        // Flush coinciding with an accepted push must drop that beat too.
        tick(4, 1, 'h11, 0, 0, p);
        tick(4, 1, 'h12, 0, 0, p);
        tick(4, 1, 'hAA, 1, 1, p);
        for (int i = 0; i < 4; i++) begin
            tick(4, 0, 0, 1, 0, p);
            sample(4);
            checks++;
            if (s_vo !== 1'b0 || s_cnt !== 0 || s_ri !== 1'b1) begin
                errors++;
                $display("FAIL flush_push cyc%0d: valid=%b data=%0h count=%0d ready=%b, want 0 - 0 1",
                         i, s_vo, s_d, s_cnt, s_ri);
            end
        end
    endtask

    task automatic test_random(input int which, input int depth, input int th, input int want,
                               input int max_cyc, input bit use_flush, input int dmask);
        bit p;
        int accepted = 0;
        apply_reset(depth, th);
        for (int c = 0; c < max_cyc && accepted < want; c++) begin
            tick(which, $urandom_range(0, 99) < 70, int'($urandom) & dmask, $urandom_range(0, 1) == 1,
                 use_flush && ($urandom_range(0, 149) == 0), p);
            if (p) accepted++;
            sample(which);
            checks++;
            if (s_vo !== (mq.size() > 0) || s_ri !== m_ready || s_cnt !== mq.size()
                || s_af !== (mq.size() >= m_th)) begin
                errors++;
                $display("FAIL rand_d%0d cyc%0d: valid=%b ready=%b count=%0d afull=%b, want %b %b %0d %b",
                         depth, c, s_vo, s_ri, s_cnt, s_af, mq.size() > 0, m_ready, mq.size(), mq.size() >= m_th);
            end
            if (mq.size() > 0) begin
                checks++;
                if (s_d !== mq[0]) begin
                    errors++;
                    $display("FAIL rand_data_d%0d cyc%0d: data=%0h want %0h", depth, c, s_d, mq[0]);
                end
            end
        end
        checks++;
        if (accepted < want) begin
            errors++;
            $display("FAIL rand_budget_d%0d: accepted %0d want %0d", depth, accepted, want);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        drive(4, 0, 0, 0, 0);
        drive(3, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_random(3, 3, 3, 1000, 6000, 1'b1, 'hFFFF);
        test_random(1, 1, 2, 500, 3000, 1'b0, 'hFF);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/skid_fifo_pipe.md
# skid_fifo_pipe

Parametrised registered-ready pipe stage for MSM datapaths that need deeper decoupling than a single backup slot. It has a registered output stage plus a DEPTH-entry circular backup FIFO. `ready_i` is driven purely from flops, so the ready chain is cut regardless of downstream latency. It also adds synchronous flush, occupancy reporting and an almost-full flag, so upstream schedulers can throttle several cycles early.

## Interface
- `WIDTH`, 1, payload width in bits.
- `DEPTH`, 2, number of backup entries; legal range ≥ 1. With DEPTH=1 the behaviour is cycle-equivalent to the single-slot backup stage, plus the flush, count and afull features.
- `AFULL_TH`, DEPTH, `afull_o` asserts when occupancy ≥ AFULL_TH; legal range 1..DEPTH+1.
- `CW`, $clog2(DEPTH+2), occupancy counter width; derived, not overridden.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rstN`  in  1  asynchronous, active-low reset.
- `valid_i`  in  1  upstream valid.
- `ready_i`  out  1  upstream ready; registered output.
- `data_i`  in  WIDTH  upstream payload.
- `valid_o`  out  1  downstream valid; registered output.
- `ready_o`  in  1  downstream ready.
- `data_o`  out  WIDTH  downstream payload; registered output.
- `flush_i`  in  1  synchronous discard of all held entries.
- `count_o`  out  CW  occupancy: valid_o + backup entry count, range 0..DEPTH+1.
- `afull_o`  out  1  count_o ≥ AFULL_TH; registered output.

## Operation
- **Handshake events.** Define `push = valid_i && ready_i` and `pop = valid_o && ready_o`.
- **Storage.** The output register holds the oldest entry. The backup FIFO is a circular buffer with head/tail pointers that wrap at DEPTH-1→0, plus a backup count `bcnt` in the range 0..DEPTH.
- **Output refill.** The output register refills when it is empty or being popped (`!valid_o || ready_o`):
  - from the backup head if `bcnt > 0` (head advances);
  - otherwise from `data_i` if push;
  - otherwise `valid_o` becomes 0.
  - Otherwise the output register holds; `data_o` must stay stable while `valid_o && !ready_o`.
- **Backup write.** A pushed beat not loaded into the output register is written at the tail (tail advances).
- **Simultaneous events.** Push and backup-drain in the same cycle are allowed, so `bcnt` is unchanged. Ordering is strictly FIFO across all paths.
- **Ready.** `ready_i` next-state is `bcnt_next < DEPTH`. Full backup deasserts ready one cycle after the fill, never combinationally.
- **No overflow.** A push accepted while `ready_i=1` never overflows, because ready reflects space for one more beat after the worst case of no pop.
- **Flush.** When `flush_i=1`, next state is `valid_o=0`, `bcnt=0`, pointers=0 and `count_o=0`. Flush overrides any push or pop in that cycle:
  - a push handshake in that cycle is consumed and dropped;
  - a pop in that cycle still counts as delivered to downstream.
  - `ready_i` next-state is 1.
- **Derived flags.** `count_o` and `afull_o` are registered and reflect the state after the edge, consistent with `valid_o` and `bcnt`.
- **Data registers.** `data_o` and the backup RAM hold stale values when invalid. The backup RAM has no reset.

## Timing
- **Reset values.** Asynchronous on `rstN` low: `valid_o=0`, `data_o=0`, `ready_i=0`, `count_o=0`, `afull_o=0`, pointers=0, `bcnt=0`.
- **Ready after reset.** `ready_i` rises on the first rising edge after `rstN` deasserts. No beat is accepted while in reset.
- **Latency.** Input to output is 1 cycle when the stage is empty. Otherwise it is 1 + number of older entries.
- **Throughput.** 1 beat/cycle sustained whenever `ready_o=1`.
- **Ready response time.** `ready_i` drops 1 cycle after `bcnt` reaches DEPTH, and rises 1 cycle after a drain frees a slot. With `ready_o` held high it never drops.
- **Reset mid-operation.** All entries are lost. `valid_o` drops immediately (asynchronously). There is no partial state.
- **Critical-path constraint.** No combinational path from `ready_o` or `valid_i` to `ready_i`. `ready_o` only feeds flop enables.

## Test plan
- **Reset:** hold `rstN=0` with `valid_i=1` → `ready_i=0`, `valid_o=0`, `count_o=0`. After release, `ready_i=1` on edge 1 and the first beat appears on `data_o` one cycle after acceptance.
- **Streaming:** DEPTH=4, `ready_o=1`, 100 beats 0..99 back-to-back → `data_o` shows 0..99 in order, one per cycle, with `ready_i` never low.
- **Backpressure fill:** DEPTH=4, `ready_o=0`, push 0,1,2,… → exactly 5 beats accepted (`count_o`=5). `ready_i` is low from the cycle after the 5th push; with AFULL_TH=4, `afull_o` is high after the 4th. Release `ready_o` → output 0..4 in order, then 5.. resumes.
- **Pointer wrap:** DEPTH=3, random `ready_o` (50%) over 1000 beats → scoreboard matches and the pointers wrap many times.
- **Flush:** DEPTH=4, `ready_o=0`, count=5, then `flush_i=1` together with push of 0xAA → next cycle `valid_o=0`, `count_o=0`, `ready_i=1`. 0xAA never appears on the output.
- **DEPTH=1 equivalence:** run the same random trace as a single-slot backup model → `valid_o`, `data_o` and `ready_i` traces are identical cycle-for-cycle after the first post-reset edge.
